data_bus_arbiter: RTL and testbench



---
 rtl/data_bus_arbiter_if.sv | 48 ++++
 rtl/data_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// Master-side and memory-side signals of the shared data bus arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters'/memory view.
interface data_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_address;
    logic [31:0] m0_write_data;
    logic [2:0]  m0_format;
    logic        m0_ready;
    logic [31:0] m0_read_data;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_address;
    logic [31:0] m1_write_data;
    logic [2:0]  m1_format;
    logic        m1_ready;
    logic [31:0] m1_read_data;

    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_format;
    logic [31:0] mem_data_fetched;

    logic [1:0]  grant;

    modport slave (
        input  m0_req, m0_we, m0_address, m0_write_data, m0_format,
        output m0_ready, m0_read_data,
        input  m1_req, m1_we, m1_address, m1_write_data, m1_format,
        output m1_ready, m1_read_data,
        output mem_read_enable, mem_write_enable, mem_address, mem_write_data, mem_format,
        input  mem_data_fetched,
        output grant
    );

    modport master (
        output m0_req, m0_we, m0_address, m0_write_data, m0_format,
        input  m0_ready, m0_read_data,
        output m1_req, m1_we, m1_address, m1_write_data, m1_format,
        input  m1_ready, m1_read_data,
        input  mem_read_enable, mem_write_enable, mem_address, mem_write_data, mem_format,
        output mem_data_fetched,
        input  grant
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter/sequencer for the data memory bus; round-robin, or fixed m0 priority with DATA_BUS_ARBITER_FIXED_PRIORITY_EN.
// Latency: strobe 1 cycle after req sampled, ready 2 (write) or 2+READ_LATENCY (read) cycles after.
// Backpressure: one transaction in flight; requests are only sampled in IDLE, the loser simply keeps req high.
module data_bus_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    data_bus_arbiter_if.slave  bus
);

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("data_bus_arbiter: READ_LATENCY must be 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        any_req;
    logic        pick_m1;
    logic        start_txn;
    logic        cnt_done;
    logic        finish;
    logic        owner_m1;
    logic        cmd_we;
    logic [2:0]  lat_cnt;

    logic        sel_we;
    logic [31:0] sel_address;
    logic [31:0] sel_write_data;
    logic [2:0]  sel_format;

    assign any_req = bus.m0_req | bus.m1_req;

`ifdef DATA_BUS_ARBITER_FIXED_PRIORITY_EN
    assign pick_m1 = bus.m1_req & ~bus.m0_req;
`else
    logic last_m1;

    // On a tie the master that was not granted last wins.
    assign pick_m1 = bus.m1_req & (~bus.m0_req | ~last_m1);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_m1 <= 1'b1;
        end else if (start_txn) begin
            last_m1 <= pick_m1;
        end
    end
`endif

    assign sel_we         = pick_m1 ? bus.m1_we         : bus.m0_we;
    assign sel_address    = pick_m1 ? bus.m1_address    : bus.m0_address;
    assign sel_write_data = pick_m1 ? bus.m1_write_data : bus.m0_write_data;
    assign sel_format     = pick_m1 ? bus.m1_format     : bus.m0_format;

    assign cnt_done = (lat_cnt == 3'd1);
    assign finish   = ((state == ISSUE) && cmd_we) || ((state == WAIT) && cnt_done);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_txn = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    start_txn = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = cmd_we ? DONE : WAIT;
            WAIT:    if (cnt_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The mem_* fields are loaded on the IDLE->ISSUE edge so they are registered and
    // valid during ISSUE, then simply hold until the next transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_m1             <= 1'b0;
            cmd_we               <= 1'b0;
            lat_cnt              <= 3'd0;
            bus.grant            <= 2'b00;
            bus.mem_read_enable  <= 1'b0;
            bus.mem_write_enable <= 1'b0;
            bus.mem_address      <= 32'd0;
            bus.mem_write_data   <= 32'd0;
            bus.mem_format       <= 3'd0;
            bus.m0_ready         <= 1'b0;
            bus.m1_ready         <= 1'b0;
            bus.m0_read_data     <= 32'd0;
            bus.m1_read_data     <= 32'd0;
        end else begin
            bus.mem_read_enable  <= start_txn & ~sel_we;
            bus.mem_write_enable <= start_txn &  sel_we;
            bus.m0_ready         <= finish & ~owner_m1;
            bus.m1_ready         <= finish &  owner_m1;

            if (start_txn) begin
                owner_m1           <= pick_m1;
                cmd_we             <= sel_we;
                bus.grant          <= pick_m1 ? 2'b10 : 2'b01;
                bus.mem_address    <= sel_address;
                bus.mem_write_data <= sel_write_data;
                bus.mem_format     <= sel_format;
            end else if (state == DONE) begin
                bus.grant <= 2'b00;
            end

            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end

            if ((state == WAIT) && cnt_done) begin
                if (owner_m1) begin
                    bus.m1_read_data <= bus.mem_data_fetched;
                end else begin
                    bus.m0_read_data <= bus.mem_data_fetched;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter with READ_LATENCY=2; honours DATA_BUS_ARBITER_FIXED_PRIORITY_EN.
// Stimulus pushes expected mem strobes and ready pulses; a negedge monitor pops and compares them.
module tb_data_bus_arbiter;

    localparam int RL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    data_bus_arbiter_if bus();

    data_bus_arbiter #(.READ_LATENCY(RL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  fmt;
        logic [1:0]  grant;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  rdy;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  grant;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];
    mem_exp_t me;
    rsp_exp_t re;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd0 = 32'd0;
    logic [31:0] exp_rd1 = 32'd0;

    // Memory model: returns data exactly READ_LATENCY cycles after the read strobe, junk otherwise.
    int          rd_due = -1;
    logic [31:0] rd_val = 32'd0;

    function automatic logic [31:0] mem_contents(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'h1234_5678;
            32'h0000_0300: return 32'hC0DE_0300;
            default:       return 32'h5555_0000 ^ a;
        endcase
    endfunction

    always @(negedge clock) begin
        if (bus.mem_read_enable) begin
            rd_due = cyc + RL;
            rd_val = mem_contents(bus.mem_address);
        end
    end

    always @(posedge clock) begin
        #1;
        bus.mem_data_fetched = (cyc == rd_due) ? rd_val : (32'hBAD0_0000 ^ 32'(cyc));
    end

    always @(negedge clock) begin
        if (bus.mem_read_enable || bus.mem_write_enable) begin
            checks++;
            if (mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_strobe: unexpected strobe cycle=%0d re=%b we=%b addr=%h", cyc,
                         bus.mem_read_enable, bus.mem_write_enable, bus.mem_address);
            end else begin
                me = mem_q.pop_front();
                if (me.cyc != cyc || me.re !== bus.mem_read_enable || me.we !== bus.mem_write_enable ||
                    me.addr !== bus.mem_address || me.wdata !== bus.mem_write_data ||
                    me.fmt !== bus.mem_format || me.grant !== bus.grant) begin
                    errors++;
                    $display("FAIL mem_txn: got cyc=%0d re=%b we=%b addr=%h wd=%h fmt=%b gnt=%b, want cyc=%0d re=%b we=%b addr=%h wd=%h fmt=%b gnt=%b",
                             cyc, bus.mem_read_enable, bus.mem_write_enable, bus.mem_address,
                             bus.mem_write_data, bus.mem_format, bus.grant,
                             me.cyc, me.re, me.we, me.addr, me.wdata, me.fmt, me.grant);
                end
            end
        end
        if (bus.m0_ready || bus.m1_ready) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL ready: unexpected ready cycle=%0d m1/m0=%b%b", cyc, bus.m1_ready, bus.m0_ready);
            end else begin
                re = rsp_q.pop_front();
                if (re.cyc != cyc || re.rdy !== {bus.m1_ready, bus.m0_ready} ||
                    re.rd0 !== bus.m0_read_data || re.rd1 !== bus.m1_read_data || re.grant !== bus.grant) begin
                    errors++;
                    $display("FAIL ready_txn: got cyc=%0d rdy=%b rd0=%h rd1=%h gnt=%b, want cyc=%0d rdy=%b rd0=%h rd1=%h gnt=%b",
                             cyc, {bus.m1_ready, bus.m0_ready}, bus.m0_read_data, bus.m1_read_data, bus.grant,
                             re.cyc, re.rdy, re.rd0, re.rd1, re.grant);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        if (!m) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_address = a; bus.m0_write_data = d; bus.m0_format = f;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_address = a; bus.m1_write_data = d; bus.m1_format = f;
        end
    endtask

    // n is the IDLE cycle in which the request is sampled; returns the ready cycle.
    task automatic expect_txn(input int n, input bit m, input bit we, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] f, input logic [31:0] rd,
                              output int rc);
        logic [1:0] g;
        g = m ? 2'b10 : 2'b01;
        mem_q.push_back('{cyc: n + 1, re: ~we, we: we, addr: a, wdata: d, fmt: f, grant: g});
        if (!we) begin
            if (m) exp_rd1 = rd;
            else   exp_rd0 = rd;
        end
        rc = we ? n + 2 : n + 2 + RL;
        rsp_q.push_back('{cyc: rc, rdy: g, rd0: exp_rd0, rd1: exp_rd1, grant: g});
    endtask

    task automatic single(input bit m, input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input logic [31:0] rd);
        int n;
        int rc;
        n = cyc;
        drive(m, 1'b1, we, a, d, f);
        expect_txn(n, m, we, a, d, f, rd, rc);
        wait_to(rc);
        drive(m, 1'b0, we, a, d, f);
        wait_to(rc + 1);
    endtask

    task automatic check_zero(input string name);
        @(negedge clock);
        checks++;
        if ({bus.mem_read_enable, bus.mem_write_enable, bus.mem_address, bus.mem_write_data,
             bus.mem_format, bus.grant} !== '0) begin
            errors++;
            $display("FAIL %s_mem: re=%b we=%b addr=%h wd=%h fmt=%b gnt=%b, want all 0", name,
                     bus.mem_read_enable, bus.mem_write_enable, bus.mem_address, bus.mem_write_data,
                     bus.mem_format, bus.grant);
        end
        checks++;
        if ({bus.m0_ready, bus.m1_ready, bus.m0_read_data, bus.m1_read_data} !== '0) begin
            errors++;
            $display("FAIL %s_master: rdy0=%b rdy1=%b rd0=%h rd1=%h, want all 0", name,
                     bus.m0_ready, bus.m1_ready, bus.m0_read_data, bus.m1_read_data);
        end
    endtask

    initial begin
        int n;
        int rc;
        bit order [4];
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        bus.mem_data_fetched = 32'd0;
        reset = 1'b1;

        repeat (2) next_cycle();
        check_zero("reset");
        next_cycle();
        reset = 1'b0;
        next_cycle();

        single(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 32'd0);
        single(1'b1, 1'b0, 32'h0000_0200, 32'd0,         3'b010, 32'h1234_5678);
        single(1'b0, 1'b0, 32'h0000_0300, 32'd0,         3'b100, 32'hC0DE_0300);
        // Write to m0 must leave m0_read_data holding the previous load.
        single(1'b0, 1'b1, 32'h0000_0104, 32'h0000_CAFE, 3'b001, 32'd0);

        // Reset while an m0 read sits in WAIT: strobe happens, ready never does.
        n = cyc;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 3'b010);
        mem_q.push_back('{cyc: n + 1, re: 1'b1, we: 1'b0, addr: 32'h0000_0300, wdata: 32'd0,
                          fmt: 3'b010, grant: 2'b01});
        wait_to(n + 2);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'd0, 3'b010);
        wait_to(n + 3);
        check_zero("mid_reset");
        next_cycle();
        reset = 1'b0;
        exp_rd0 = 32'd0;
        exp_rd1 = 32'd0;
        single(1'b1, 1'b1, 32'h0000_0600, 32'h0BAD_F00D, 3'b000, 32'd0);

        // Both masters held high for four write transactions.
`ifdef DATA_BUS_ARBITER_FIXED_PRIORITY_EN
        order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        n = cyc;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_00A0, 3'b010);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_00B1, 3'b001);
        for (int k = 0; k < 4; k++) begin
            if (order[k])
                expect_txn(n + 3 * k, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_00B1, 3'b001, 32'd0, rc);
            else
                expect_txn(n + 3 * k, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_00A0, 3'b010, 32'd0, rc);
        end
        wait_to(n + 11);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_00A0, 3'b010);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_00B1, 3'b001);
        wait_to(n + 12);

        // m0 holds req across three writes, updating the command in each ready cycle.
        n = cyc;
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h1111_0000, 3'b010);
        for (int k = 0; k < 3; k++) begin
            expect_txn(n + 3 * k, 1'b0, 1'b1, 32'h0000_0700 + 32'(4 * k), 32'h1111_0000 + 32'(k),
                       3'b010, 32'd0, rc);
        end
        for (int k = 0; k < 3; k++) begin
            wait_to(n + 2 + 3 * k);
            drive(1'b0, (k < 2), 1'b1, 32'h0000_0700 + 32'(4 * (k + 1)), 32'h1111_0000 + 32'(k + 1), 3'b010);
        end
        wait_to(n + 9);

        repeat (10) next_cycle();

        checks++;
        if (mem_q.size() != 0) begin
            errors++;
            $display("FAIL mem_missing: %0d expected strobes never seen, want 0", mem_q.size());
        end
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL ready_missing: %0d expected ready pulses never seen, want 0", rsp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
